// File: rtl/leg_seq_pkg.sv
// Shared types and constants for the LEG program-counter sequencer.
// Opcode class, condition-code and fault-code encodings live here so decode and ALU agree.
package leg_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFault
  } seq_state_e;

  // Opcode class is carried in opcode[5:3]
  localparam logic [2:0] CLS_BRANCH = 3'b100;
  localparam logic [2:0] CLS_CALL   = 3'b101;
  localparam logic [2:0] CLS_RET    = 3'b110;

  localparam logic [2:0] COND_EQ = 3'd0;
  localparam logic [2:0] COND_NE = 3'd1;
  localparam logic [2:0] COND_LT = 3'd2;
  localparam logic [2:0] COND_LE = 3'd3;
  localparam logic [2:0] COND_GT = 3'd4;
  localparam logic [2:0] COND_GE = 3'd5;

  localparam logic [1:0] FAULT_NONE      = 2'd0;
  localparam logic [1:0] FAULT_OVERFLOW  = 2'd1;
  localparam logic [1:0] FAULT_UNDERFLOW = 2'd2;

endpackage

// File: rtl/leg_cond_eval.sv
// Unsigned 8-bit branch-condition evaluator; shared with the ALU flag path.
// Codes 6 and 7 are reserved and always evaluate false.
module leg_cond_eval
  import leg_seq_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [7:0] arg1,
  input  logic [7:0] arg2,
  output logic       result
);

  always_comb begin
    result = 1'b0;
    case (cond)
      COND_EQ: result = (arg1 == arg2);
      COND_NE: result = (arg1 != arg2);
      COND_LT: result = (arg1 <  arg2);
      COND_LE: result = (arg1 <= arg2);
      COND_GT: result = (arg1 >  arg2);
      COND_GE: result = (arg1 >= arg2);
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/leg_pc_sequencer.sv
// LEG program-counter sequencer: owns the PC, a return-address stack and the
// IDLE/RUN/FAULT control FSM; drives the fetch address every cycle.
module leg_pc_sequencer
  import leg_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stall,
  input  logic                         instr_valid,
  input  logic [7:0]                   opcode,
  input  logic [7:0]                   arg1,
  input  logic [7:0]                   arg2,
  input  logic [ADDR_W-1:0]            target,
  input  logic                         fault_clr,
  output logic [ADDR_W-1:0]            pc,
  output logic                         pc_valid,
  output logic                         taken,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         fault,
  output logic [1:0]                   fault_code
);

  localparam int unsigned IdxW = $clog2(STACK_DEPTH);
  localparam int unsigned SpW  = IdxW + 1;

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SpW-1:0]    sp_q, sp_d;
  logic              taken_q, taken_d;
  logic [1:0]        fault_code_q, fault_code_d;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_seq;
  logic [2:0]        op_cls;
  logic              cond_true;
  logic              push_en;
  logic [SpW-1:0]    sp_dec;
  logic [IdxW-1:0]   push_idx;
  logic [IdxW-1:0]   pop_idx;
  logic              stack_full;
  logic              stack_empty;
  logic              unused_opcode;

  assign unused_opcode = ^opcode[7:6];

  assign pc_seq      = pc_q + ADDR_W'(INSTR_BYTES);
  assign op_cls      = opcode[5:3];
  assign sp_dec      = sp_q - SpW'(1);
  assign push_idx    = sp_q[IdxW-1:0];
  assign pop_idx     = sp_dec[IdxW-1:0];
  assign stack_full  = (sp_q == SpW'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);

  leg_cond_eval u_cond_eval (
    .cond   (opcode[2:0]),
    .arg1   (arg1),
    .arg2   (arg2),
    .result (cond_true)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    sp_d         = sp_q;
    taken_d      = taken_q;
    fault_code_d = fault_code_q;
    push_en      = 1'b0;

    // stall freezes everything, FSM transitions included
    if (!stall) begin
      unique case (state_q)
        StIdle: begin
          if (start) state_d = StRun;
        end
        StRun: begin
          if (instr_valid) begin
            case (op_cls)
              CLS_BRANCH: begin
                pc_d    = cond_true ? target : pc_seq;
                taken_d = cond_true;
              end
              CLS_CALL: begin
                if (!stack_full) begin
                  push_en = 1'b1;
                  sp_d    = sp_q + SpW'(1);
                  pc_d    = target;
                  taken_d = 1'b1;
                end else begin
                  taken_d      = 1'b0;
                  fault_code_d = FAULT_OVERFLOW;
                  state_d      = StFault;
                end
              end
              CLS_RET: begin
                if (!stack_empty) begin
                  pc_d    = stack_q[pop_idx];
                  sp_d    = sp_dec;
                  taken_d = 1'b1;
                end else begin
                  taken_d      = 1'b0;
                  fault_code_d = FAULT_UNDERFLOW;
                  state_d      = StFault;
                end
              end
              default: begin
                pc_d    = pc_seq;
                taken_d = 1'b0;
              end
            endcase
          end else begin
            taken_d = 1'b0;
          end
        end
        StFault: begin
          if (fault_clr) begin
            fault_code_d = FAULT_NONE;
            state_d      = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      sp_q         <= '0;
      taken_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      sp_q         <= sp_d;
      taken_q      <= taken_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Entries need no reset: a pop is only possible once sp>0 after a push
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= pc_seq;
  end

  assign pc         = pc_q;
  assign pc_valid   = (state_q == StRun);
  assign taken      = taken_q;
  assign sp         = sp_q;
  assign fault      = (state_q == StFault);
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_leg_pc_sequencer.sv
// Self-checking bench for leg_pc_sequencer: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_leg_pc_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stall;
  logic       instr_valid;
  logic [7:0] opcode;
  logic [7:0] arg1;
  logic [7:0] arg2;
  logic [7:0] target;
  logic       fault_clr;
  logic [7:0] pc;
  logic       pc_valid;
  logic       taken;
  logic [3:0] sp;
  logic       fault;
  logic [1:0] fault_code;

  int n_cmp;
  int n_bad;

  // Reference model: mode 0 idle, 1 run, 2 fault; stack as a queue
  int m_mode;
  int m_pc;
  int m_taken;
  int m_code;
  int m_stack[$];

  leg_pc_sequencer #(
    .ADDR_W      (8),
    .STACK_DEPTH (8),
    .INSTR_BYTES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stall       (stall),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .arg1        (arg1),
    .arg2        (arg2),
    .target      (target),
    .fault_clr   (fault_clr),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .taken       (taken),
    .sp          (sp),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit cond_holds(input int cc, input int a, input int b);
    if (cc == 0) return a == b;
    if (cc == 1) return a != b;
    if (cc == 2) return a < b;
    if (cc == 3) return a <= b;
    if (cc == 4) return a > b;
    if (cc == 5) return a >= b;
    return 0;
  endfunction

  task automatic mdl_reset();
    m_mode  = 0;
    m_pc    = 0;
    m_taken = 0;
    m_code  = 0;
    m_stack.delete();
  endtask

  task automatic mdl_step();
    int cls;
    bit t;
    if (stall) return;
    if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 2) begin
      if (fault_clr) begin
        m_mode = 1;
        m_code = 0;
      end
    end else if (!instr_valid) begin
      m_taken = 0;
    end else begin
      cls = int'(opcode[5:3]);
      if (cls == 4) begin
        t       = cond_holds(int'(opcode[2:0]), int'(arg1), int'(arg2));
        m_pc    = t ? int'(target) : (m_pc + 4) % 256;
        m_taken = t;
      end else if (cls == 5) begin
        if (m_stack.size() < 8) begin
          m_stack.push_back((m_pc + 4) % 256);
          m_pc    = int'(target);
          m_taken = 1;
        end else begin
          m_taken = 0;
          m_code  = 1;
          m_mode  = 2;
        end
      end else if (cls == 6) begin
        if (m_stack.size() > 0) begin
          m_pc    = m_stack.pop_back();
          m_taken = 1;
        end else begin
          m_taken = 0;
          m_code  = 2;
          m_mode  = 2;
        end
      end else begin
        m_pc    = (m_pc + 4) % 256;
        m_taken = 0;
      end
    end
  endtask

  task automatic clear_inputs();
    start       = 1'b0;
    stall       = 1'b0;
    instr_valid = 1'b0;
    opcode      = 8'h00;
    arg1        = 8'h00;
    arg2        = 8'h00;
    target      = 8'h00;
    fault_clr   = 1'b0;
  endtask

  task automatic do_cycle();
    mdl_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_instr(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2,
                          input logic [7:0] tgt);
    instr_valid = 1'b1;
    opcode      = op;
    arg1        = a1;
    arg2        = a2;
    target      = tgt;
    do_cycle();
    instr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    do_cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    mdl_reset();
    #2;
    n_cmp++;
    if ({pc, sp, taken, fault, fault_code, pc_valid} !== 17'h0) begin
      n_bad++;
      $display("FAIL reset_state: got pc=%h sp=%0d taken=%b fault=%b code=%0d valid=%b, want 0",
               pc, sp, taken, fault, fault_code, pc_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    pulse_start();
    n_cmp++;
    if (pc_valid !== 1'b1 || pc !== 8'h00) begin
      n_bad++;
      $display("FAIL start_run: got valid=%b pc=%h, want valid=1 pc=00", pc_valid, pc);
    end
  endtask

  task automatic test_seq();
    logic [7:0] want;
    for (int i = 1; i <= 3; i++) begin
      do_instr(8'h00, 8'h00, 8'h00, 8'h00);
      want = 8'(4 * i);
      n_cmp++;
      if (pc !== want || taken !== 1'b0) begin
        n_bad++;
        $display("FAIL seq_%0d: got pc=%h taken=%b, want pc=%h taken=0", i, pc, taken, want);
      end
    end
  endtask

  task automatic test_branch();
    do_instr(8'h22, 8'd3, 8'd7, 8'h40);
    n_cmp++;
    if (pc !== 8'h40 || taken !== 1'b1) begin
      n_bad++;
      $display("FAIL branch_lt_taken: got pc=%h taken=%b, want pc=40 taken=1", pc, taken);
    end
    do_instr(8'h22, 8'd7, 8'd7, 8'h40);
    n_cmp++;
    if (pc !== 8'h44 || taken !== 1'b0) begin
      n_bad++;
      $display("FAIL branch_lt_not: got pc=%h taken=%b, want pc=44 taken=0", pc, taken);
    end
    do_instr(8'h26, 8'd3, 8'd7, 8'h40);
    n_cmp++;
    if (pc !== 8'h48 || taken !== 1'b0) begin
      n_bad++;
      $display("FAIL branch_cond6: got pc=%h taken=%b, want pc=48 taken=0", pc, taken);
    end
  endtask

  task automatic test_call_ret();
    do_instr(8'h20, 8'd9, 8'd9, 8'h10);
    n_cmp++;
    if (pc !== 8'h10) begin
      n_bad++;
      $display("FAIL branch_eq: got pc=%h, want pc=10", pc);
    end
    do_instr(8'h28, 8'h00, 8'h00, 8'h80);
    n_cmp++;
    if (pc !== 8'h80 || sp !== 4'd1 || taken !== 1'b1) begin
      n_bad++;
      $display("FAIL call: got pc=%h sp=%0d taken=%b, want pc=80 sp=1 taken=1", pc, sp, taken);
    end
    do_instr(8'h30, 8'h00, 8'h00, 8'h00);
    n_cmp++;
    if (pc !== 8'h14 || sp !== 4'd0 || taken !== 1'b1) begin
      n_bad++;
      $display("FAIL ret: got pc=%h sp=%0d taken=%b, want pc=14 sp=0 taken=1", pc, sp, taken);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] ret_addr [8];
    logic [7:0] cur;
    cur = 8'h14;
    for (int i = 0; i < 8; i++) begin
      ret_addr[i] = cur + 8'd4;
      cur         = 8'(8'h30 + 8 * i);
      do_instr(8'h28, 8'h00, 8'h00, cur);
    end
    n_cmp++;
    if (sp !== 4'd8 || pc !== 8'h68 || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_stack: got sp=%0d pc=%h fault=%b, want sp=8 pc=68 fault=0",
               sp, pc, fault);
    end
    do_instr(8'h28, 8'h00, 8'h00, 8'hF0);
    n_cmp++;
    if (fault !== 1'b1 || fault_code !== 2'd1 || sp !== 4'd8 || pc !== 8'h68 ||
        taken !== 1'b0 || pc_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL overflow: got fault=%b code=%0d sp=%0d pc=%h taken=%b valid=%b",
               fault, fault_code, sp, pc, taken, pc_valid);
    end
    fault_clr = 1'b1;
    do_cycle();
    fault_clr = 1'b0;
    n_cmp++;
    if (fault !== 1'b0 || fault_code !== 2'd0 || pc !== 8'h68 || pc_valid !== 1'b1 ||
        sp !== 4'd8) begin
      n_bad++;
      $display("FAIL fault_clr: got fault=%b code=%0d pc=%h valid=%b sp=%0d",
               fault, fault_code, pc, pc_valid, sp);
    end
    for (int i = 7; i >= 0; i--) begin
      do_instr(8'h30, 8'h00, 8'h00, 8'h00);
      n_cmp++;
      if (pc !== ret_addr[i] || sp !== 4'(i) || taken !== 1'b1) begin
        n_bad++;
        $display("FAIL unwind_%0d: got pc=%h sp=%0d taken=%b, want pc=%h sp=%0d taken=1",
                 i, pc, sp, taken, ret_addr[i], i);
      end
    end
  endtask

  task automatic test_underflow();
    do_instr(8'h30, 8'h00, 8'h00, 8'h00);
    n_cmp++;
    if (fault !== 1'b1 || fault_code !== 2'd2 || pc !== 8'h18 || sp !== 4'd0) begin
      n_bad++;
      $display("FAIL underflow: got fault=%b code=%0d pc=%h sp=%0d, want 1 2 18 0",
               fault, fault_code, pc, sp);
    end
    fault_clr = 1'b1;
    stall     = 1'b1;
    do_cycle();
    n_cmp++;
    if (fault !== 1'b1 || fault_code !== 2'd2) begin
      n_bad++;
      $display("FAIL stall_fault_clr: got fault=%b code=%0d, want fault=1 code=2",
               fault, fault_code);
    end
    stall = 1'b0;
    do_cycle();
    fault_clr = 1'b0;
    n_cmp++;
    if (fault !== 1'b0 || pc_valid !== 1'b1 || fault_code !== 2'd0 || pc !== 8'h18) begin
      n_bad++;
      $display("FAIL unstall_clr: got fault=%b valid=%b code=%0d pc=%h",
               fault, pc_valid, fault_code, pc);
    end
  endtask

  task automatic test_wrap();
    do_instr(8'h20, 8'd5, 8'd5, 8'hFC);
    do_instr(8'h07, 8'h00, 8'h00, 8'h00);
    n_cmp++;
    if (pc !== 8'h00 || taken !== 1'b0) begin
      n_bad++;
      $display("FAIL pc_wrap: got pc=%h taken=%b, want pc=00 taken=0", pc, taken);
    end
  endtask

  task automatic test_async_reset();
    do_instr(8'h28, 8'h00, 8'h00, 8'h40);
    do_instr(8'h28, 8'h00, 8'h00, 8'h50);
    do_instr(8'h28, 8'h00, 8'h00, 8'h60);
    n_cmp++;
    if (sp !== 4'd3 || pc !== 8'h60) begin
      n_bad++;
      $display("FAIL pre_reset: got sp=%0d pc=%h, want sp=3 pc=60", sp, pc);
    end
    #3;
    rst = 1'b0;
    mdl_reset();
    #1;
    n_cmp++;
    if (pc !== 8'h00 || sp !== 4'd0 || pc_valid !== 1'b0 || taken !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got pc=%h sp=%0d valid=%b taken=%b, want 0 0 0 0",
               pc, sp, pc_valid, taken);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    pulse_start();
  endtask

  task automatic test_random();
    logic [16:0] got;
    logic [16:0] want;
    for (int i = 0; i < 400; i++) begin
      clear_inputs();
      stall       = ($urandom_range(0, 9) < 2);
      instr_valid = ($urandom_range(0, 9) < 8);
      start       = ($urandom_range(0, 9) < 2);
      fault_clr   = ($urandom_range(0, 9) < 3);
      opcode      = 8'($urandom);
      arg1        = 8'($urandom_range(0, 3));
      arg2        = 8'($urandom_range(0, 3));
      target      = 8'($urandom);
      do_cycle();
      got  = {pc, sp, taken, fault, fault_code, pc_valid};
      want = {8'(m_pc), 4'(m_stack.size()), m_taken != 0, m_mode == 2, 2'(m_code), m_mode == 1};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL random_%0d: got {pc,sp,tk,f,code,v}=%h, want %h", i, got, want);
      end
    end
    clear_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_seq();
    test_branch();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
